// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read port, exact occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module fifo_sync #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic [WIDTH-1:0]      dataWrite,
  input  logic                  read,
  output logic [WIDTH-1:0]      dataRead,
  output logic                  dataReadReady,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clearErrors
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   AF_C    = (DEPTH_LOG2 + 1)'(AF_LEVEL);
  localparam logic [DEPTH_LOG2:0]   AE_C    = (DEPTH_LOG2 + 1)'(AE_LEVEL);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr_wr_q, ptr_wr_d;
  logic [DEPTH_LOG2-1:0] ptr_rd_q, ptr_rd_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      data_rd_q, data_rd_d;
  logic                  rd_rdy_q, rd_rdy_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_ok, rd_ok;

  // A read at full frees a slot in the same cycle, so the write is still taken.
  assign wr_ok = write && (!full || read);
  assign rd_ok = read && !empty;

  always_comb begin
    ptr_wr_d  = ptr_wr_q;
    ptr_rd_d  = ptr_rd_q;
    count_d   = count_q;
    data_rd_d = data_rd_q;
    rd_rdy_d  = rd_ok;
    if (wr_ok) ptr_wr_d = ptr_wr_q + PTR_ONE;
    if (rd_ok) begin
      ptr_rd_d  = ptr_rd_q + PTR_ONE;
      data_rd_d = mem_q[ptr_rd_q];
    end
    if (wr_ok && !rd_ok)      count_d = count_q + CNT_ONE;
    else if (!wr_ok && rd_ok) count_d = count_q - CNT_ONE;
    // A rejection in the same cycle as clearErrors leaves the flag set.
    ovf_d = (ovf_q && !clearErrors) || (write && !wr_ok);
    udf_d = (udf_q && !clearErrors) || (read && !rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_wr_q  <= '0;
      ptr_rd_q  <= '0;
      count_q   <= '0;
      data_rd_q <= '0;
      rd_rdy_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      ptr_wr_q  <= ptr_wr_d;
      ptr_rd_q  <= ptr_rd_d;
      count_q   <= count_d;
      data_rd_q <= data_rd_d;
      rd_rdy_q  <= rd_rdy_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage is deliberately unreset; stale contents are never observable.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[ptr_wr_q] <= dataWrite;
  end

  assign dataRead      = data_rd_q;
  assign dataReadReady = rd_rdy_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;
  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  assign almostFull    = (count_q >= AF_C);
  assign almostEmpty   = (count_q <= AE_C);

endmodule
